// File: rtl/yuv_sched_pkg.sv
// Shared definitions for the YUV->RGB frame scheduler.
//   sched_state_t  : FSM state encoding (4-bit, IDLE = 0)
//   ENG_*          : engine-select codes identifying which engine a WAIT state listens to
//   wait_engine    : maps a state to the engine whose done pulse it samples
//   is_start_state : true in the states that issue a start pulse (watchdog clear)
package yuv_sched_pkg;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_U_START  = 4'd1,
        ST_U_WAIT   = 4'd2,
        ST_V_START  = 4'd3,
        ST_V_WAIT   = 4'd4,
        ST_C_START  = 4'd5,
        ST_C_WAIT   = 4'd6,
        ST_ROW_NEXT = 4'd7,
        ST_DONE     = 4'd8
    } sched_state_t;

    localparam logic [1:0] ENG_NONE = 2'd0;
    localparam logic [1:0] ENG_U    = 2'd1;
    localparam logic [1:0] ENG_V    = 2'd2;
    localparam logic [1:0] ENG_C    = 2'd3;

    function automatic logic [1:0] wait_engine(input sched_state_t s);
        case (s)
            ST_U_WAIT: return ENG_U;
            ST_V_WAIT: return ENG_V;
            ST_C_WAIT: return ENG_C;
            default:   return ENG_NONE;
        endcase
    endfunction

    function automatic logic is_start_state(input sched_state_t s);
        return (s == ST_U_START) || (s == ST_V_START) || (s == ST_C_START);
    endfunction

endpackage

// File: rtl/yuv_frame_scheduler_watchdog.sv
// sched_watchdog: per-wait cycle counter for the frame scheduler.
//   i_clk, i_rst : clock, async active-high reset
//   i_clear      : zero the count (asserted in the cycle before a WAIT state)
//   i_run        : a WAIT state is active this cycle
//   o_expired    : this is the TIMEOUT_CYCLES-th consecutive waiting cycle
module sched_watchdog #(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int TO_W           = 13
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_run,
    output logic o_expired
);

    localparam logic [TO_W-1:0] LP_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] r_cnt;

    // First waiting cycle sees count 0, so expiry lands on the last allowed cycle.
    assign o_expired = i_run && (r_cnt == LP_LAST);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_run && !o_expired) begin
            r_cnt <= r_cnt + TO_W'(1);
        end
    end

endmodule

// File: rtl/yuv_frame_scheduler.sv
// yuv_frame_scheduler: per-row sequencer for the U upsampler, V upsampler and colour converter.
// Ports:
//   i_clk, i_rst                : clock, async active-high reset
//   i_frame_start, i_abort      : host request (honoured in IDLE) / cancel (any state)
//   o_up_u_start, i_up_u_done   : U upsampler handshake
//   o_up_v_start, i_up_v_done   : V upsampler handshake
//   o_csc_start,  i_csc_done    : colour converter handshake
//   o_row_idx                   : row being processed
//   o_frame_busy, o_frame_done  : status / 1-cycle completion pulse
//   o_err_timeout               : sticky watchdog error, cleared by rst or accepted frame_start
// Build option: define SCHED_OVERLAP_EN to start U and V together and wait for both in U_WAIT.
module yuv_frame_scheduler
    import yuv_sched_pkg::*;
#(
    parameter int ROWS           = 240,
    parameter int ROW_W          = 9,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int TO_W           = 13
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_frame_start,
    input  logic             i_abort,
    output logic             o_up_u_start,
    input  logic             i_up_u_done,
    output logic             o_up_v_start,
    input  logic             i_up_v_done,
    output logic             o_csc_start,
    input  logic             i_csc_done,
    output logic [ROW_W-1:0] o_row_idx,
    output logic             o_frame_busy,
    output logic             o_frame_done,
    output logic             o_err_timeout
);

    localparam logic [ROW_W-1:0] LP_LAST_ROW = ROW_W'(ROWS - 1);

    sched_state_t     r_state, w_state_nxt;
    logic [ROW_W-1:0] r_row_idx;
    logic             r_err_timeout;
    logic             w_accept, w_set_err, w_row_inc;
    logic             w_wait_done, w_wd_expired;
    logic             w_u_wait_done;

    assign w_accept = (r_state == ST_IDLE) && i_frame_start && !i_abort;

    // Done inputs are only looked at in the WAIT state that owns them.
    always_comb begin
        w_wait_done = 1'b0;
        case (wait_engine(r_state))
            ENG_U:   w_wait_done = i_up_u_done;
            ENG_V:   w_wait_done = i_up_v_done;
            ENG_C:   w_wait_done = i_csc_done;
            default: w_wait_done = 1'b0;
        endcase
    end

`ifdef SCHED_OVERLAP_EN
    logic r_u_seen, r_v_seen;

    // Either engine may finish first; remember each pulse until both have arrived.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_u_seen <= 1'b0;
            r_v_seen <= 1'b0;
        end else if (r_state == ST_U_START) begin
            r_u_seen <= 1'b0;
            r_v_seen <= 1'b0;
        end else if (r_state == ST_U_WAIT) begin
            if (i_up_u_done) r_u_seen <= 1'b1;
            if (i_up_v_done) r_v_seen <= 1'b1;
        end
    end

    assign w_u_wait_done = (r_u_seen || i_up_u_done) && (r_v_seen || i_up_v_done);
`else
    assign w_u_wait_done = w_wait_done;
`endif

    sched_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TO_W           (TO_W)
    ) u_watchdog (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_clear   (is_start_state(r_state)),
        .i_run     (wait_engine(r_state) != ENG_NONE),
        .o_expired (w_wd_expired)
    );

    // Next state. A done on the expiry cycle is checked first and therefore wins.
    always_comb begin
        w_state_nxt = r_state;
        w_set_err   = 1'b0;
        w_row_inc   = 1'b0;
        case (r_state)
            ST_IDLE:     if (i_frame_start) w_state_nxt = ST_U_START;
            ST_U_START:  w_state_nxt = ST_U_WAIT;
            ST_U_WAIT: begin
`ifdef SCHED_OVERLAP_EN
                if (w_u_wait_done)     w_state_nxt = ST_C_START;
`else
                if (w_u_wait_done)     w_state_nxt = ST_V_START;
`endif
                else if (w_wd_expired) begin
                    w_state_nxt = ST_IDLE;
                    w_set_err   = 1'b1;
                end
            end
            ST_V_START:  w_state_nxt = ST_V_WAIT;
            ST_V_WAIT: begin
                if (w_wait_done)       w_state_nxt = ST_C_START;
                else if (w_wd_expired) begin
                    w_state_nxt = ST_IDLE;
                    w_set_err   = 1'b1;
                end
            end
            ST_C_START:  w_state_nxt = ST_C_WAIT;
            ST_C_WAIT: begin
                if (w_wait_done)       w_state_nxt = ST_ROW_NEXT;
                else if (w_wd_expired) begin
                    w_state_nxt = ST_IDLE;
                    w_set_err   = 1'b1;
                end
            end
            ST_ROW_NEXT: begin
                if (r_row_idx == LP_LAST_ROW) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_U_START;
                    w_row_inc   = 1'b1;
                end
            end
            ST_DONE:     w_state_nxt = ST_IDLE;
            default:     w_state_nxt = ST_IDLE;
        endcase
        // Abort overrides everything; row_idx is left where it was.
        if (i_abort) begin
            w_state_nxt = ST_IDLE;
            w_set_err   = 1'b0;
            w_row_inc   = 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= ST_IDLE;
            r_row_idx     <= '0;
            r_err_timeout <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_row_idx     <= '0;
                r_err_timeout <= 1'b0;
            end else begin
                if (w_row_inc) r_row_idx     <= r_row_idx + ROW_W'(1);
                if (w_set_err) r_err_timeout <= 1'b1;
            end
        end
    end

    // Pulses are gated by abort so a cancelled cycle never starts an engine.
    assign o_up_u_start  = (r_state == ST_U_START) && !i_abort;
`ifdef SCHED_OVERLAP_EN
    assign o_up_v_start  = (r_state == ST_U_START) && !i_abort;
`else
    assign o_up_v_start  = (r_state == ST_V_START) && !i_abort;
`endif
    assign o_csc_start   = (r_state == ST_C_START) && !i_abort;
    assign o_frame_done  = (r_state == ST_DONE) && !i_abort;
    assign o_frame_busy  = (r_state != ST_IDLE);
    assign o_row_idx     = r_row_idx;
    assign o_err_timeout = r_err_timeout;

endmodule
